pong_score_unit: RTL and testbench

- Scoring and end-of-game rendering block for the two-player pong design.
- Counts points for both players from wall-hit events and converts each score into two 7-segment digit patterns for the on-screen scoreboard.
- Latches the winner when a score reaches the selected target.
- Produces pixel masks for the end-game banner ("P1"/"P2" and "WIN"), which the top-level colour mux consumes.

---
 rtl/pong_score_unit_if.sv | 31 +++
 rtl/pong_score_unit.sv | 149 ++++++++++++++
 tb/tb_pong_score_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_score_unit_if.sv
// Signal bundle between the pong top level and the scoring / end-game banner unit.
// The master side supplies wall hits, the target score and the pixel position; the slave side returns the results.
interface pong_score_unit_if;
    logic       left_hit;
    logic       right_hit;
    logic [4:0] max_score;
    logic [9:0] x;
    logic [9:0] y;
    logic [4:0] score_p1;
    logic [4:0] score_p2;
    logic [6:0] seg_p1_tens;
    logic [6:0] seg_p1_ones;
    logic [6:0] seg_p2_tens;
    logic [6:0] seg_p2_ones;
    logic [1:0] winner;
    logic       game_over;
    logic       end_player_px;
    logic       end_win_px;

    modport master (
        output left_hit, right_hit, max_score, x, y,
        input  score_p1, score_p2, seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones,
        input  winner, game_over, end_player_px, end_win_px
    );

    modport slave (
        input  left_hit, right_hit, max_score, x, y,
        output score_p1, score_p2, seg_p1_tens, seg_p1_ones, seg_p2_tens, seg_p2_ones,
        output winner, game_over, end_player_px, end_win_px
    );
endinterface

// File: rtl/pong_score_unit.sv
// Pong scoring: edge-detected wall hits feed saturating scores, win latch, 7-seg digit codes,
// and a registered "P1/P2 ... WIN" banner pixel mask for the end-game screen.
module pong_score_unit #(
    parameter int END_X0 = 229,
    parameter int END_Y0 = 220,
    parameter int SCALE  = 4,
    parameter int PITCH  = 24
) (
    input logic              clk_pix,
    input logic              reset,
    pong_score_unit_if.slave bus
);
    localparam logic [9:0] X0      = 10'(END_X0);
    localparam logic [9:0] Y0      = 10'(END_Y0);
    localparam logic [9:0] WIN_W   = 10'(6 * PITCH);
    localparam logic [9:0] WIN_H   = 10'(7 * SCALE);
    localparam logic [9:0] PITCH_W = 10'(PITCH);
    localparam logic [9:0] SCALE_W = 10'(SCALE);
    localparam logic [4:0] SCORE_MAX = 5'd31;

    // Each glyph is 7 rows of 5 bits, top row in the most significant bits.
    localparam logic [34:0] GLYPH_P = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
    localparam logic [34:0] GLYPH_1 = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
    localparam logic [34:0] GLYPH_2 = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
    localparam logic [34:0] GLYPH_W = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
    localparam logic [34:0] GLYPH_I = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
    localparam logic [34:0] GLYPH_N = {5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11, 5'h11};

    logic       left_prev_reg, right_prev_reg;
    logic [4:0] score_p1_reg, score_p2_reg;
    logic [1:0] winner_reg;
    logic       game_over_reg;
    logic       player_px_reg, win_px_reg;
    logic       player_px_next, win_px_next;

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            left_prev_reg  <= 1'b0;
            right_prev_reg <= 1'b0;
            score_p1_reg   <= '0;
            score_p2_reg   <= '0;
            winner_reg     <= '0;
            game_over_reg  <= 1'b0;
            player_px_reg  <= 1'b0;
            win_px_reg     <= 1'b0;
        end else begin
            left_prev_reg  <= bus.left_hit;
            right_prev_reg <= bus.right_hit;
            player_px_reg  <= player_px_next;
            win_px_reg     <= win_px_next;
            if (!game_over_reg) begin
                if (bus.right_hit && !right_prev_reg && score_p1_reg != SCORE_MAX)
                    score_p1_reg <= score_p1_reg + 5'd1;
                if (bus.left_hit && !left_prev_reg && score_p2_reg != SCORE_MAX)
                    score_p2_reg <= score_p2_reg + 5'd1;
                // Compared against the registered scores, so the win shows one cycle after the point.
                if (bus.max_score != 5'd0) begin
                    if (score_p1_reg == bus.max_score) begin
                        winner_reg    <= 2'd1;
                        game_over_reg <= 1'b1;
                    end else if (score_p2_reg == bus.max_score) begin
                        winner_reg    <= 2'd2;
                        game_over_reg <= 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] tens_of(input logic [4:0] s);
        if (s >= 5'd30)      tens_of = 4'd3;
        else if (s >= 5'd20) tens_of = 4'd2;
        else if (s >= 5'd10) tens_of = 4'd1;
        else                 tens_of = 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] s);
        ones_of = 4'(s - 5'(tens_of(s)) * 5'd10);
    endfunction

    // Digit slots: 0 P1 tens, 1 P1 ones, 2 P2 tens, 3 P2 ones.
    logic [6:0] seg_code [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_seg
        logic [4:0] src;
        assign src          = (gi >= 2) ? score_p2_reg : score_p1_reg;
        assign seg_code[gi] = seg7(((gi % 2) == 0) ? tens_of(src) : ones_of(src));
    end

    logic [9:0]  dx, dy, k_full, col_full, row_full;
    logic        in_window;
    logic [2:0]  row_sel, col_sel, bit_sel;
    logic [5:0]  shamt;
    logic [34:0] glyph;
    logic [4:0]  glyph_row;
    logic        lit;

    always_comb begin
        dx        = bus.x - X0;
        dy        = bus.y - Y0;
        in_window = (bus.x >= X0) && (bus.y >= Y0) && (dx < WIN_W) && (dy < WIN_H);
        k_full    = dx / PITCH_W;
        col_full  = (dx % PITCH_W) / SCALE_W;
        row_full  = dy / SCALE_W;
        // Clamp selectors so the glyph slicing stays in range outside the window.
        row_sel   = (row_full < 10'd7) ? row_full[2:0] : 3'd0;
        col_sel   = (col_full < 10'd5) ? col_full[2:0] : 3'd0;
        bit_sel   = 3'd4 - col_sel;
        shamt     = 6'd5 * (6'd6 - {3'b000, row_sel});
        case (k_full)
            10'd0:   glyph = GLYPH_P;
            10'd1:   glyph = (winner_reg == 2'd2) ? GLYPH_2 : GLYPH_1;
            10'd3:   glyph = GLYPH_W;
            10'd4:   glyph = GLYPH_I;
            10'd5:   glyph = GLYPH_N;
            default: glyph = '0;
        endcase
        glyph_row      = glyph[shamt +: 5];
        lit            = in_window && (col_full < 10'd5) && glyph_row[bit_sel] && (winner_reg != 2'd0);
        player_px_next = lit && (k_full <= 10'd1);
        win_px_next    = lit && (k_full >= 10'd3) && (k_full <= 10'd5);
    end

    assign bus.score_p1      = score_p1_reg;
    assign bus.score_p2      = score_p2_reg;
    assign bus.seg_p1_tens   = seg_code[0];
    assign bus.seg_p1_ones   = seg_code[1];
    assign bus.seg_p2_tens   = seg_code[2];
    assign bus.seg_p2_ones   = seg_code[3];
    assign bus.winner        = winner_reg;
    assign bus.game_over     = game_over_reg;
    assign bus.end_player_px = player_px_reg;
    assign bus.end_win_px    = win_px_reg;
endmodule

// File: tb/tb_pong_score_unit.sv
// Bench for pong_score_unit: directed scenarios plus random hits and pixel positions,
// every cycle compared against an arithmetic reference model of scores, win and banner.
module tb_pong_score_unit;
    logic clk_pix = 1'b0;
    logic reset;
    always #5 clk_pix = ~clk_pix;

    pong_score_unit_if bus ();

    pong_score_unit dut (
        .clk_pix (clk_pix),
        .reset   (reset),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    // Glyph order: P, 1, 2, W, I, N
    int font [6][7] = '{
        '{'h1E, 'h11, 'h11, 'h1E, 'h10, 'h10, 'h10},
        '{'h04, 'h0C, 'h04, 'h04, 'h04, 'h04, 'h0E},
        '{'h0E, 'h11, 'h01, 'h02, 'h04, 'h08, 'h1F},
        '{'h11, 'h11, 'h11, 'h15, 'h15, 'h15, 'h0A},
        '{'h0E, 'h04, 'h04, 'h04, 'h04, 'h04, 'h0E},
        '{'h11, 'h19, 'h15, 'h13, 'h11, 'h11, 'h11}
    };

    int m_s1, m_s2, m_win, m_go, m_pp, m_pw, m_pl, m_pr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int banner(input int px, input int py, input int w, input int want_win);
        int dx, dy, k, col, row, g, b;
        if (w == 0) return 0;
        dx = px - 229;
        dy = py - 220;
        if (dx < 0 || dy < 0 || dx >= 144 || dy >= 28) return 0;
        k   = dx / 24;
        col = (dx % 24) / 4;
        row = dy / 4;
        if (col >= 5 || k == 2) return 0;
        g = (k == 0) ? 0 : (k == 1) ? w : k;
        b = (font[g][row] >> (4 - col)) & 1;
        if (want_win != 0) return (k >= 3) ? b : 0;
        return (k <= 1) ? b : 0;
    endfunction

    task automatic check_all();
        check("score_p1", bus.score_p1, m_s1);
        check("score_p2", bus.score_p2, m_s2);
        check("seg_p1_tens", bus.seg_p1_tens, seg_tab[m_s1 / 10]);
        check("seg_p1_ones", bus.seg_p1_ones, seg_tab[m_s1 % 10]);
        check("seg_p2_tens", bus.seg_p2_tens, seg_tab[m_s2 / 10]);
        check("seg_p2_ones", bus.seg_p2_ones, seg_tab[m_s2 % 10]);
        check("winner", bus.winner, m_win);
        check("game_over", bus.game_over, m_go);
        check("end_player_px", bus.end_player_px, m_pp);
        check("end_win_px", bus.end_win_px, m_pw);
    endtask

    // Advance one clock: the model reacts to the inputs present before the edge.
    task automatic tick();
        int n_s1, n_s2, n_win, n_go, n_pp, n_pw, n_pl, n_pr;
        int lh, rh, ms;
        lh = int'(bus.left_hit);
        rh = int'(bus.right_hit);
        ms = int'(bus.max_score);
        if (reset) begin
            n_s1 = 0; n_s2 = 0; n_win = 0; n_go = 0; n_pp = 0; n_pw = 0; n_pl = 0; n_pr = 0;
        end else begin
            n_s1 = m_s1; n_s2 = m_s2; n_win = m_win; n_go = m_go;
            n_pl = lh; n_pr = rh;
            if (m_go == 0) begin
                if (rh == 1 && m_pr == 0 && m_s1 < 31) n_s1 = m_s1 + 1;
                if (lh == 1 && m_pl == 0 && m_s2 < 31) n_s2 = m_s2 + 1;
                if (ms != 0) begin
                    if (m_s1 == ms) begin n_win = 1; n_go = 1; end
                    else if (m_s2 == ms) begin n_win = 2; n_go = 1; end
                end
            end
            n_pp = banner(int'(bus.x), int'(bus.y), m_win, 0);
            n_pw = banner(int'(bus.x), int'(bus.y), m_win, 1);
        end
        @(posedge clk_pix);
        #1;
        m_s1 = n_s1; m_s2 = n_s2; m_win = n_win; m_go = n_go;
        m_pp = n_pp; m_pw = n_pw; m_pl = n_pl; m_pr = n_pr;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic pulse(input bit l, input bit r, input int hold, input int gap);
        bus.left_hit  = l;
        bus.right_hit = r;
        repeat (hold) tick();
        bus.left_hit  = 1'b0;
        bus.right_hit = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic probe(input int px, input int py);
        bus.x = 10'(px);
        bus.y = 10'(py);
        tick();
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        bus.left_hit  = 1'b0;
        bus.right_hit = 1'b0;
        bus.max_score = 5'd0;
        bus.x         = 10'd0;
        bus.y         = 10'd0;
        m_s1 = 0; m_s2 = 0; m_win = 0; m_go = 0; m_pp = 0; m_pw = 0; m_pl = 0; m_pr = 0;

        do_reset();
        check("rst_score_p1", bus.score_p1, 0);
        check("rst_winner", bus.winner, 0);

        // Three separate right_hit pulses
        repeat (3) pulse(1'b0, 1'b1, 5, 3);
        check("tp1_score_p1", bus.score_p1, 3);
        check("tp1_score_p2", bus.score_p2, 0);
        check("tp1_seg_tens", bus.seg_p1_tens, 'h3F);
        check("tp1_seg_ones", bus.seg_p1_ones, 'h4F);

        // Long left_hit counts once, then simultaneous edges
        pulse(1'b1, 1'b0, 100, 2);
        check("long_hit_p2", bus.score_p2, 1);
        pulse(1'b1, 1'b1, 1, 2);
        check("both_p1", bus.score_p1, 4);
        check("both_p2", bus.score_p2, 2);

        // Win for P2 with one-cycle latency
        do_reset();
        bus.max_score = 5'd5;
        repeat (4) pulse(1'b1, 1'b0, 2, 2);
        bus.left_hit = 1'b1;
        tick();
        check("win_score_p2", bus.score_p2, 5);
        check("win_latency_go", bus.game_over, 0);
        tick();
        check("win_winner", bus.winner, 2);
        check("win_game_over", bus.game_over, 1);
        bus.left_hit = 1'b0;
        tick();
        repeat (3) pulse(1'b1, 1'b1, 2, 2);
        bus.max_score = 5'd0;
        tick();
        check("frozen_p1", bus.score_p1, 0);
        check("frozen_p2", bus.score_p2, 5);
        check("frozen_winner", bus.winner, 2);
        do_reset();
        check("clr_p2", bus.score_p2, 0);
        check("clr_go", bus.game_over, 0);

        // Score 27 then saturation
        repeat (27) pulse(1'b0, 1'b1, 1, 1);
        check("s27_tens", bus.seg_p1_tens, 'h5B);
        check("s27_ones", bus.seg_p1_ones, 'h07);
        repeat (13) pulse(1'b0, 1'b1, 1, 1);
        check("sat_score", bus.score_p1, 31);
        check("sat_tens", bus.seg_p1_tens, 'h4F);
        check("sat_ones", bus.seg_p1_ones, 'h06);
        check("sat_winner", bus.winner, 0);

        // Banner with winner=1
        do_reset();
        bus.max_score = 5'd1;
        pulse(1'b0, 1'b1, 1, 2);
        check("banner_winner", bus.winner, 1);
        for (int yy = 220; yy <= 247; yy++)
            for (int xx = 229; xx <= 372; xx++)
                probe(xx, yy);
        probe(229, 220);
        check("pt_p_topleft", bus.end_player_px, 1);
        bus.x = 10'd228;
        #1;
        check("pt_lag_hold", bus.end_player_px, 1);
        tick();
        check("pt_left_out_pp", bus.end_player_px, 0);
        check("pt_left_out_pw", bus.end_win_px, 0);
        probe(249, 220);
        check("pt_col5_gap", bus.end_player_px, 0);
        probe(301, 220);
        check("pt_w_topleft", bus.end_win_px, 1);
        probe(229, 248);
        check("pt_below_pp", bus.end_player_px, 0);
        check("pt_below_pw", bus.end_win_px, 0);

        // No winner: masks never assert over a sparse frame
        do_reset();
        seen = 0;
        for (int yy = 0; yy < 480; yy += 5)
            for (int xx = 0; xx < 640; xx += 7) begin
                probe(xx, yy);
                if (bus.end_player_px || bus.end_win_px) seen++;
            end
        for (int yy = 218; yy <= 250; yy++)
            for (int xx = 227; xx <= 374; xx += 3) begin
                probe(xx, yy);
                if (bus.end_player_px || bus.end_win_px) seen++;
            end
        check("w0_any_px", seen, 0);

        // Randomized phase
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.left_hit  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.right_hit = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) bus.max_score = 5'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) bus.max_score = 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 399) == 0);
            bus.x = 10'($urandom_range(220, 380));
            bus.y = 10'($urandom_range(212, 255));
            tick();
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
